hazard_stall_ctrl: RTL and testbench

//  Parametrised hazard-detection and stall controller for the 5-stage RV32 pipeline. It sits beside cu.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/hazard_stall_ctrl_mem_wait_cnt.sv | 27 ++
 rtl/hazard_stall_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline-control types for the RV32 core.
package riscv_pkg;

  localparam int REG_AW_DEF = 5;

  // Hazard controller states: normal flow, second load->branch bubble, data-memory freeze
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_mem_wait_cnt.sv
// Memory-wait cycle counter: clear / load-to-1 / saturating increment, plus a
// flag telling the controller the configured latency has been reached.
module mem_wait_cnt #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic load,
  input  logic inc,
  input  logic clr,
  output logic at_lat
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over load, load over increment; increment stops at all-ones
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                   cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (load)               cnt <= CNT_W'(1);
    else if (inc && cnt != '1)   cnt <= cnt + CNT_W'(1);
  end

  assign at_lat = (cnt == CNT_W'(MEM_LAT));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall control for the 5-stage RV32 pipeline.
// Produces per-stage register enables, bubble/flush strobes and the PC enable.
// Outputs are combinational from state and inputs; only the state, the
// memory-wait counter and the deferred-flush flag are registered.
module hazard_stall_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MEM_LAT  = 3,
  parameter bit BR_IN_ID = 1'b1,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_use,
  input  logic              id_rs2_use,
  input  logic              id_is_br,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              ex_we,
  input  logic              mem_we,
  input  logic              ex_ld,
  input  logic              mem_ld,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              mispredict,
  input  logic              ext_stall,
  output logic              pc_en,
  output logic              fd_en,
  output logic              de_en,
  output logic              em_en,
  output logic              mw_en,
  output logic              de_bubble,
  output logic              fd_flush,
  output logic              mem_busy
);

  hz_state_t state, state_nxt;
  logic      flush_pend, flush_pend_nxt;
  logic      cnt_load, cnt_inc, cnt_clr, at_lat;
  logic      m_ex, m_mem, mem_start;

  // x0 is never a real producer, so rd==0 cannot create a hazard
  assign m_ex  = ex_we  && (ex_rd  != '0) &&
                 ((id_rs1_use && id_rs1 == ex_rd)  || (id_rs2_use && id_rs2 == ex_rd));
  assign m_mem = mem_we && (mem_rd != '0) &&
                 ((id_rs1_use && id_rs1 == mem_rd) || (id_rs2_use && id_rs2 == mem_rd));

  // A zero-latency memory never freezes; ready in the request cycle needs no wait
  assign mem_start = (MEM_LAT > 0) && dmem_req && !dmem_ready;

  mem_wait_cnt #(
    .MEM_LAT (MEM_LAT),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .nrst   (nrst),
    .load   (cnt_load),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_lat (at_lat)
  );

  // Output decode and next state; priority ext_stall > memory wait > flush > data hazard
  always_comb begin
    pc_en          = 1'b0;
    fd_en          = 1'b0;
    de_en          = 1'b0;
    em_en          = 1'b0;
    mw_en          = 1'b0;
    de_bubble      = 1'b0;
    fd_flush       = 1'b0;
    mem_busy       = nrst && (state == MEM_WAIT);
    state_nxt      = state;
    flush_pend_nxt = flush_pend;
    cnt_load       = 1'b0;
    cnt_inc        = 1'b0;
    cnt_clr        = 1'b0;

    if (!nrst) begin
      state_nxt = RUN;
    end else if (ext_stall) begin
      // Frozen: a mispredict here must survive until the pipeline moves again
      if (mispredict) flush_pend_nxt = 1'b1;
    end else if (state == MEM_WAIT) begin
      if (dmem_ready || at_lat) begin
        // Release cycle: everything advances, hazards are not re-checked this cycle
        {pc_en, fd_en, de_en, em_en, mw_en} = '1;
        state_nxt = RUN;
        cnt_clr   = 1'b1;
        if (mispredict || flush_pend) begin
          fd_flush       = 1'b1;
          de_bubble      = 1'b1;
          flush_pend_nxt = 1'b0;
        end
      end else begin
        cnt_inc = 1'b1;
        if (mispredict) flush_pend_nxt = 1'b1;
      end
    end else if (mem_start) begin
      // Entering the wait is itself the first frozen cycle; an open BR_HOLD is dropped
      // and the branch hazard is simply re-detected after release
      cnt_load  = 1'b1;
      state_nxt = MEM_WAIT;
      if (mispredict) flush_pend_nxt = 1'b1;
    end else begin
      {pc_en, fd_en, de_en, em_en, mw_en} = '1;
      state_nxt = RUN;
      if (mispredict || flush_pend) begin
        // The flushed ID instruction no longer matters, so no stall is needed
        fd_flush       = 1'b1;
        de_bubble      = 1'b1;
        flush_pend_nxt = 1'b0;
      end else if (state == BR_HOLD) begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        de_bubble = 1'b1;
      end else if (m_ex && ex_ld) begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        de_bubble = 1'b1;
        // Branch compares in ID, so the load must reach WB: one more bubble
        if (BR_IN_ID && id_is_br) state_nxt = BR_HOLD;
      end else if (BR_IN_ID && id_is_br && (m_ex || (m_mem && mem_ld))) begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        de_bubble = 1'b1;
      end
    end
  end

  // Controller state and deferred-flush flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= RUN;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural reference model.
module tb_hazard_stall_ctrl;

  localparam int MEM_LAT = 3;
  localparam bit BR_IN_ID = 1'b1;

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2, br;
    logic [4:0] exrd, memrd;
    logic       exwe, memwe, exld, memld;
    logic       req, rdy, mis, ext;
  } in_t;

  typedef struct {
    in_t        x;
    logic [7:0] e;
    string      n;
  } vec_t;

  // {pc_en, fd_en, de_en, em_en, mw_en, de_bubble, fd_flush, mem_busy}
  localparam logic [7:0] RUNO  = 8'b11111_00_0;
  localparam logic [7:0] STALL = 8'b00111_10_0;
  localparam logic [7:0] FLUSH = 8'b11111_11_0;
  localparam logic [7:0] FRZ   = 8'b00000_00_0;
  localparam logic [7:0] BUSY  = 8'b00000_00_1;
  localparam logic [7:0] REL   = 8'b11111_00_1;
  localparam logic [7:0] RELF  = 8'b11111_11_1;

  logic       clk = 1'b0;
  logic       nrst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_rs1_use, id_rs2_use, id_is_br, ex_we, mem_we, ex_ld, mem_ld;
  logic       dmem_req, dmem_ready, mispredict, ext_stall;
  logic       pc_en, fd_en, de_en, em_en, mw_en, de_bubble, fd_flush, mem_busy;

  int errors = 0;
  int checks = 0;

  vec_t tbl[$];

  // Reference model state
  int mw_cycles;
  bit second_bubble;
  bit flush_owed;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .REG_AW   (5),
    .MEM_LAT  (MEM_LAT),
    .BR_IN_ID (BR_IN_ID),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_use (id_rs1_use),
    .id_rs2_use (id_rs2_use),
    .id_is_br   (id_is_br),
    .ex_rd      (ex_rd),
    .mem_rd     (mem_rd),
    .ex_we      (ex_we),
    .mem_we     (mem_we),
    .ex_ld      (ex_ld),
    .mem_ld     (mem_ld),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .mispredict (mispredict),
    .ext_stall  (ext_stall),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .de_en      (de_en),
    .em_en      (em_en),
    .mw_en      (mw_en),
    .de_bubble  (de_bubble),
    .fd_flush   (fd_flush),
    .mem_busy   (mem_busy)
  );

  function automatic in_t mk(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                             input bit u2, input bit br, input logic [4:0] exrd, input bit exwe,
                             input bit exld, input logic [4:0] memrd, input bit memwe,
                             input bit memld);
    in_t x;
    x = '0;
    x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2; x.br = br;
    x.exrd = exrd; x.exwe = exwe; x.exld = exld;
    x.memrd = memrd; x.memwe = memwe; x.memld = memld;
    return x;
  endfunction

  function automatic in_t fl(input in_t xi, input bit req, input bit rdy, input bit mis,
                             input bit ext);
    in_t x;
    x = xi;
    x.req = req; x.rdy = rdy; x.mis = mis; x.ext = ext;
    return x;
  endfunction

  function automatic void add(input in_t x, input logic [7:0] e, input string n);
    vec_t v;
    v.x = x; v.e = e; v.n = n;
    tbl.push_back(v);
  endfunction

  task automatic drive(input in_t x);
    id_rs1 = x.rs1; id_rs2 = x.rs2; id_rs1_use = x.u1; id_rs2_use = x.u2; id_is_br = x.br;
    ex_rd = x.exrd; ex_we = x.exwe; ex_ld = x.exld;
    mem_rd = x.memrd; mem_we = x.memwe; mem_ld = x.memld;
    dmem_req = x.req; dmem_ready = x.rdy; mispredict = x.mis; ext_stall = x.ext;
  endtask

  task automatic check(input string n, input logic [7:0] exp);
    logic [7:0] act;
    act = {pc_en, fd_en, de_en, em_en, mw_en, de_bubble, fd_flush, mem_busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (pc fd de em mw bub flush busy)", n, act, exp);
    end
  endtask

  // Apply one cycle of inputs, compare combinational outputs mid-cycle, advance
  task automatic cyc(input in_t x, input logic [7:0] exp, input string n);
    drive(x);
    @(negedge clk);
    check(n, exp);
    @(posedge clk);
    #1;
  endtask

  // Reference model: rules applied directly on per-cycle inputs
  task automatic model(input in_t x, output logic [7:0] e);
    bit hit_ex, hit_mem, flush, stall;
    hit_ex  = x.exwe  && x.exrd  != 0 &&
              ((x.u1 && x.rs1 == x.exrd)  || (x.u2 && x.rs2 == x.exrd));
    hit_mem = x.memwe && x.memrd != 0 &&
              ((x.u1 && x.rs1 == x.memrd) || (x.u2 && x.rs2 == x.memrd));
    e = {7'b0, mw_cycles > 0};
    if (x.ext) begin
      flush_owed |= x.mis;
      return;
    end
    if (mw_cycles > 0) begin
      if (x.rdy || mw_cycles == MEM_LAT) begin
        flush = x.mis || flush_owed;
        e = {5'b11111, flush, flush, 1'b1};
        mw_cycles = 0; flush_owed = 0; second_bubble = 0;
      end else begin
        mw_cycles++;
        flush_owed |= x.mis;
      end
      return;
    end
    if (MEM_LAT > 0 && x.req && !x.rdy) begin
      mw_cycles = 1; second_bubble = 0; flush_owed |= x.mis;
      return;
    end
    flush = x.mis || flush_owed;
    flush_owed = 0;
    if (flush) begin
      e = FLUSH; second_bubble = 0;
      return;
    end
    stall = second_bubble || (hit_ex && x.exld) ||
            (BR_IN_ID && x.br && (hit_ex || (hit_mem && x.memld)));
    second_bubble = !second_bubble && BR_IN_ID && x.br && hit_ex && x.exld;
    e = stall ? STALL : RUNO;
  endtask

  initial begin
    in_t idle, x;
    logic [7:0] e;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nrst = 1'b0;
    drive(idle);
    @(negedge clk);
    check("rst_outs", FRZ);
    @(posedge clk);
    #1 nrst = 1'b1;

    // rs1 u1 rs2 u2 br | exrd we ld | memrd we ld
    add(idle,                                          RUNO,  "idle");
    add(mk(5, 1, 1, 1, 0,  5, 1, 1,  0, 0, 0),         STALL, "ld_use");
    add(mk(5, 1, 1, 1, 0,  0, 0, 0,  5, 1, 1),         RUNO,  "ld_use_after");
    add(mk(5, 1, 0, 1, 1,  5, 1, 1,  0, 0, 0),         STALL, "ldbr_1");
    add(mk(5, 1, 0, 1, 1,  0, 0, 0,  5, 1, 1),         STALL, "ldbr_2");
    add(mk(5, 1, 0, 1, 1,  0, 0, 0,  0, 0, 0),         RUNO,  "ldbr_3");
    add(mk(0, 1, 0, 1, 0,  0, 1, 0,  0, 0, 0),         RUNO,  "x0_no_haz");
    add(mk(1, 1, 7, 1, 1,  7, 1, 0,  0, 0, 0),         STALL, "alu_br");
    add(mk(1, 1, 7, 1, 1,  0, 0, 0,  7, 1, 0),         RUNO,  "alu_br_after");
    add(mk(8, 1, 2, 1, 1,  0, 0, 0,  8, 1, 1),         STALL, "memld_br");
    add(mk(9, 0, 2, 1, 0,  9, 1, 1,  0, 0, 0),         RUNO,  "rs1_unused");
    add(mk(3, 1, 10, 1, 0, 10, 1, 1, 0, 0, 0),         STALL, "ld_use_rs2");
    add(mk(11, 1, 0, 0, 0, 11, 0, 1, 0, 0, 0),         RUNO,  "no_we");
    add(fl(mk(5, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0), 0, 0, 1, 0), FLUSH, "mis_over_hz");
    add(fl(mk(5, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0), 0, 0, 0, 1), FRZ,   "ext_over_hz");
    add(idle,                                          RUNO,  "ext_after");
    add(fl(idle, 0, 0, 1, 1),                          FRZ,   "ext_mis");
    add(idle,                                          FLUSH, "ext_mis_rel");
    add(idle,                                          RUNO,  "ext_mis_after");

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i].x, tbl[i].e, tbl[i].n);

    // Full-latency memory wait
    cyc(fl(idle, 1, 0, 0, 0), FRZ,  "mw_enter");
    cyc(idle,                 BUSY, "mw_1");
    cyc(idle,                 BUSY, "mw_2");
    cyc(idle,                 REL,  "mw_rel");
    cyc(idle,                 RUNO, "mw_after");

    // Early exit on ready in the second wait cycle
    cyc(fl(idle, 1, 0, 0, 0), FRZ,  "mwe_enter");
    cyc(fl(idle, 0, 1, 0, 0), REL,  "mwe_rel");
    cyc(idle,                 RUNO, "mwe_after");

    // Mispredict while frozen is deferred to the release cycle
    cyc(fl(idle, 1, 0, 0, 0), FRZ,  "mwm_enter");
    cyc(fl(idle, 0, 0, 1, 0), BUSY, "mwm_mis");
    cyc(idle,                 BUSY, "mwm_2");
    cyc(idle,                 RELF, "mwm_rel");
    cyc(idle,                 RUNO, "mwm_after");

    // Reset in the middle of a wait
    cyc(fl(idle, 1, 0, 0, 0), FRZ,  "mwr_enter");
    drive(idle);
    @(negedge clk);
    check("mwr_busy", BUSY);
    #2 nrst = 1'b0;
    #1;
    check("rst_mid", FRZ);
    checks++;
    if (dut.u_cnt.cnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d expected 0", dut.u_cnt.cnt);
    end
    @(posedge clk);
    #1;
    check("rst_hold", FRZ);
    nrst = 1'b1;
    @(negedge clk);
    check("rst_after", RUNO);
    @(posedge clk);
    #1;
    cyc(fl(idle, 1, 0, 0, 0), FRZ,  "mwr2_enter");
    cyc(idle,                 BUSY, "mwr2_1");
    cyc(idle,                 BUSY, "mwr2_2");
    cyc(idle,                 REL,  "mwr2_rel");

    // Randomized traffic against the reference model, from a fresh reset
    nrst = 1'b0;
    drive(idle);
    @(posedge clk);
    #1 nrst = 1'b1;
    mw_cycles = 0; second_bubble = 0; flush_owed = 0;
    for (int i = 0; i < 600; i++) begin
      x = '0;
      x.rs1   = 5'($urandom_range(0, 3));
      x.rs2   = 5'($urandom_range(0, 3));
      x.exrd  = 5'($urandom_range(0, 3));
      x.memrd = 5'($urandom_range(0, 3));
      x.u1    = ($urandom % 4) != 0;
      x.u2    = ($urandom % 4) != 0;
      x.br    = ($urandom % 3) == 0;
      x.exwe  = ($urandom % 4) != 0;
      x.memwe = ($urandom % 4) != 0;
      x.exld  = ($urandom % 2) != 0;
      x.memld = ($urandom % 2) != 0;
      x.req   = ($urandom % 8) == 0;
      x.rdy   = ($urandom % 4) == 0;
      x.mis   = ($urandom % 8) == 0;
      x.ext   = ($urandom % 8) == 0;
      model(x, e);
      cyc(x, e, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
